// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size and FSM state
// encodings, plus the lane-index helper used by extract and merge.
// Build option: define LSU_BIG_ENDIAN_EN to select big-endian lane numbering.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } state_e;

    // Byte offset of the addressed lane within the 32-bit word.
    // Word accesses always start at offset 0.
    function automatic logic [1:0] lane_index(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [1:0] lane;
        lane = 2'd0;
        if (size == SZ_BYTE) begin
`ifdef LSU_BIG_ENDIAN_EN
            lane = 2'd3 - addr_lo;
`else
            lane = addr_lo;
`endif
        end else if (size == SZ_HALF) begin
`ifdef LSU_BIG_ENDIAN_EN
            lane = {~addr_lo[1], 1'b0};
`else
            lane = {addr_lo[1], 1'b0};
`endif
        end
        return lane;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side handshake and data-memory bus of the load/store unit.
// slave: the LSU itself; master: the core plus memory driving it.
interface load_store_unit_if;
    logic        req;
    logic        we_in;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        misaligned;
    logic        out_of_range;
    logic [31:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  req, we_in, size, sign_ext, addr, wdata, mem_rd,
        output busy, done, rdata, misaligned, out_of_range, mem_a, mem_we, mem_wd
    );

    modport master (
        output req, we_in, size, sign_ext, addr, wdata, mem_rd,
        input  busy, done, rdata, misaligned, out_of_range, mem_a, mem_we, mem_wd
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends a sub-word load from the
// memory word, and merges sub-word store data into a previously read word.
// Lane numbering follows lsu_pkg::lane_index (LSU_BIG_ENDIAN_EN aware).
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rd_word,
    input  logic [31:0] base_word,
    input  logic [15:0] wdata_lo,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [4:0]  shift;
    logic [31:0] shifted;
    logic [31:0] lane_mask;
    logic [31:0] insert;

    assign shift   = {lane_index(size, addr_lo), 3'b000};
    assign shifted = rd_word >> shift;

    // Extract the addressed lane and zero- or sign-extend it.
    always_comb begin
        load_val = shifted;
        case (size)
            SZ_BYTE: load_val = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_val = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    // Replace only the addressed lane of the read word with the store data.
    always_comb begin
        if (size == SZ_BYTE) begin
            lane_mask = 32'h0000_00FF << shift;
            insert    = {24'h0, wdata_lo[7:0]} << shift;
        end else begin
            lane_mask = 32'h0000_FFFF << shift;
            insert    = {16'h0, wdata_lo} << shift;
        end
        merged = (base_word & ~lane_mask) | insert;
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the core MEM stage and a word-only data memory.
// Sub-word stores are done as read-modify-write; misaligned and
// out-of-range requests complete immediately with a fault flag.
// Build option: LSU_BIG_ENDIAN_EN selects big-endian lanes (see lsu_pkg).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 516
) (
    input  logic clk,
    input  logic reset,
    load_store_unit_if.slave bus
);

    state_e      state_reg;
    state_e      state_next;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf_q;
    logic [31:0] rdata_reg;
    logic        misaligned_reg;
    logic        out_of_range_reg;

    logic        accept;
    logic        misaligned_next;
    logic        out_of_range_next;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign accept = (state_reg == IDLE) && bus.req;

    assign misaligned_next = (bus.size == SZ_RSVD)
                           || ((bus.size == SZ_HALF) && bus.addr[0])
                           || ((bus.size == SZ_WORD) && (bus.addr[1:0] != 2'b00));
    assign out_of_range_next = {2'b00, bus.addr[31:2]} >= 32'(DEPTH_WORDS);

    lsu_lane_align u_align (
        .size      (size_q),
        .sign_ext  (sign_q),
        .addr_lo   (addr_q[1:0]),
        .rd_word   (bus.mem_rd),
        .base_word (rbuf_q),
        .wdata_lo  (wdata_q[15:0]),
        .load_val  (load_val),
        .merged    (merged)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state: faults skip straight to DONE; sub-word stores read first.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.req) begin
                    if (misaligned_next || out_of_range_next) state_next = DONE;
                    else if (!bus.we_in)                       state_next = READ;
                    else if (bus.size == SZ_WORD)              state_next = WRITE;
                    else                                       state_next = READ;
                end
            end
            READ:    state_next = we_q ? WRITE : DONE;
            WRITE:   state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch, fault flags, read buffer and load result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q             <= 1'b0;
            size_q           <= 2'b00;
            sign_q           <= 1'b0;
            addr_q           <= 32'h0;
            wdata_q          <= 32'h0;
            rbuf_q           <= 32'h0;
            rdata_reg        <= 32'h0;
            misaligned_reg   <= 1'b0;
            out_of_range_reg <= 1'b0;
        end else begin
            if (accept) begin
                we_q             <= bus.we_in;
                size_q           <= bus.size;
                sign_q           <= bus.sign_ext;
                addr_q           <= bus.addr;
                wdata_q          <= bus.wdata;
                misaligned_reg   <= misaligned_next;
                out_of_range_reg <= out_of_range_next;
            end
            if (state_reg == READ) begin
                rbuf_q <= bus.mem_rd;
                if (!we_q) rdata_reg <= load_val;
            end
        end
    end

    // Memory write enable depends on state alone so a reset kills it at once.
    assign bus.mem_we       = (state_reg == WRITE);
    assign bus.mem_wd       = (size_q == SZ_WORD) ? wdata_q : merged;
    assign bus.mem_a        = {addr_q[31:2], 2'b00};
    assign bus.busy         = (state_reg != IDLE);
    assign bus.done         = (state_reg == DONE);
    assign bus.rdata        = rdata_reg;
    assign bus.misaligned   = misaligned_reg;
    assign bus.out_of_range = out_of_range_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed steps plus randomized accesses checked
// against an arithmetic reference model of memory, lanes and faults.
module tb_load_store_unit;
    localparam int DEPTH = 516;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit #(.DEPTH_WORDS(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural word memory with combinational read.
    logic [31:0] mem [0:DEPTH-1];
    logic        pre_we = 1'b0;
    int          pre_idx = 0;
    logic [31:0] pre_data = 32'h0;
    int          total_we = 0;

    always_comb begin
        bus.mem_rd = 32'h0;
        if (bus.mem_a[31:2] < 30'(DEPTH)) bus.mem_rd = mem[bus.mem_a[31:2]];
    end

    always @(posedge clk) begin
        if (bus.mem_we) begin
            total_we <= total_we + 1;
            if (bus.mem_a[31:2] < 30'(DEPTH)) mem[bus.mem_a[31:2]] <= bus.mem_wd;
        end else if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [0:DEPTH-1];
    logic [31:0] exp_rdata;
    int compared = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte offset of the addressed lane (0 = bits 7:0).
    function automatic int lane_of(input int sz, input logic [31:0] a);
`ifdef LSU_BIG_ENDIAN_EN
        if (sz == 0) return 3 - int'(a % 4);
        return (1 - int'((a / 2) % 2)) * 2;
`else
        if (sz == 0) return int'(a % 4);
        return int'((a / 2) % 2) * 2;
`endif
    endfunction

    task automatic preload(input int idx, input logic [31:0] v);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_data = v;
        ref_mem[idx] = v;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic run_op(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd, input string tag);
        logic        e_mis, e_oor, fault;
        int          e_lat, idx, sh, lat, pulses;
        logic [31:0] word, v, unit, new_word, obs_a, obs_wd;
        e_mis = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
        e_oor = (a / 4) >= DEPTH;
        fault = e_mis || e_oor;
        idx = int'(a / 4);
        word = fault ? 32'h0 : ref_mem[idx];
        new_word = word;
        if (fault)                    e_lat = 1;
        else if (!w || sz == 2'd2)    e_lat = 2;
        else                          e_lat = 3;
        if (!fault) begin
            if (sz == 2'd2) begin
                v = word;
                new_word = wd;
            end else begin
                unit = (sz == 2'd0) ? 32'd256 : 32'd65536;
                sh = lane_of(int'(sz), a);
                v = (word >> (8 * sh)) % unit;
                if (sx && v >= unit / 2) v = v - unit;
                new_word = word - (((word >> (8 * sh)) % unit) << (8 * sh))
                                + ((wd % unit) << (8 * sh));
            end
            if (!w) exp_rdata = v;
        end

        @(negedge clk);
        bus.req = 1'b1; bus.we_in = w; bus.size = sz; bus.sign_ext = sx;
        bus.addr = a; bus.wdata = wd;
        @(posedge clk);
        #1 bus.req = 1'b0;
        lat = 0; pulses = 0; obs_a = 32'h0; obs_wd = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.mem_we) begin
                pulses++; obs_a = bus.mem_a; obs_wd = bus.mem_wd;
            end
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(e_lat));
        check({tag, " misaligned"}, {31'h0, bus.misaligned}, {31'h0, e_mis});
        check({tag, " out_of_range"}, {31'h0, bus.out_of_range}, {31'h0, e_oor});
        check({tag, " mem_we pulses"}, 32'(pulses), (w && !fault) ? 32'd1 : 32'd0);
        if (w && !fault) begin
            ref_mem[idx] = new_word;
            check({tag, " mem_a"}, obs_a, (a / 4) * 4);
            check({tag, " mem_wd"}, obs_wd, new_word);
            check({tag, " mem word"}, mem[idx], new_word);
        end
        @(negedge clk);
        check({tag, " done width"}, {31'h0, bus.done}, 32'h0);
        check({tag, " idle after"}, {31'h0, bus.busy}, 32'h0);
        check({tag, " rdata"}, bus.rdata, exp_rdata);
        $display("op %s we=%0d size=%0d sx=%0d addr=%h wdata=%h -> rdata=%h mis=%0d oor=%0d lat=%0d",
                 tag, w, sz, sx, a, wd, bus.rdata, e_mis, e_oor, lat);
    endtask

    initial begin
        int we_before;
        logic        rw, rx;
        logic [1:0]  rs;
        int          ridx;
        logic [31:0] ra;

        bus.req = 1'b0; bus.we_in = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
        bus.addr = 32'h0; bus.wdata = 32'h0;
        reset = 1'b1;
        exp_rdata = 32'h0;
        #2;
        check("reset busy", {31'h0, bus.busy}, 32'h0);
        check("reset done", {31'h0, bus.done}, 32'h0);
        check("reset mem_we", {31'h0, bus.mem_we}, 32'h0);
        check("reset misaligned", {31'h0, bus.misaligned}, 32'h0);
        check("reset out_of_range", {31'h0, bus.out_of_range}, 32'h0);
        check("reset rdata", bus.rdata, 32'h0);
        check("reset mem_a", bus.mem_a, 32'h0);

        for (int i = 0; i < DEPTH; i++) preload(i, $urandom);
        preload(4, 32'h8899AABB);
        @(negedge clk);
        reset = 1'b0;

        // Directed steps from the plan.
        run_op(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, "lb_0x11");
`ifdef LSU_BIG_ENDIAN_EN
        check("lb_0x11 literal", bus.rdata, 32'hFFFFFF99);
`else
        check("lb_0x11 literal", bus.rdata, 32'hFFFFFFAA);
`endif
        run_op(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, "lbu_0x13");
        run_op(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, "lhu_0x12");
        run_op(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, "lh_0x10");
        run_op(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000005C, "sb_0x12");
        run_op(1'b1, 2'd1, 1'b0, 32'h11, 32'h00001234, "sh_0x11");
        check("word4 after sh fault", mem[4], ref_mem[4]);
        run_op(1'b0, 2'd2, 1'b0, 32'h810, 32'h0, "lw_0x810");
        run_op(1'b1, 2'd2, 1'b0, 32'h80C, 32'hCAFEF00D, "sw_0x80C");
        run_op(1'b0, 2'd2, 1'b0, 32'h80C, 32'h0, "lw_0x80C");
        check("lw_0x80C readback", bus.rdata, 32'hCAFEF00D);
        run_op(1'b0, 2'd3, 1'b0, 32'h14, 32'h0, "rsvd_size");

        // A request raised while busy must be ignored.
        we_before = total_we;
        exp_rdata = ref_mem[4];
        @(negedge clk);
        bus.req = 1'b1; bus.we_in = 1'b0; bus.size = 2'd2; bus.addr = 32'h10;
        @(posedge clk);
        #1 bus.req = 1'b0;
        @(negedge clk);
        bus.req = 1'b1; bus.we_in = 1'b1; bus.size = 2'd2; bus.addr = 32'h20;
        bus.wdata = 32'h12345678;
        @(negedge clk);
        check("busy-req done", {31'h0, bus.done}, 32'h1);
        bus.req = 1'b0;
        @(negedge clk);
        check("busy-req idle", {31'h0, bus.busy}, 32'h0);
        check("busy-req rdata", bus.rdata, exp_rdata);
        check("busy-req no write", 32'(total_we), 32'(we_before));
        check("busy-req word8", mem[8], ref_mem[8]);
        $display("op busy_req ignored: rdata=%h writes=%0d", bus.rdata, total_we - we_before);

        // Randomized accesses against the model.
        for (int n = 0; n < 150; n++) begin
            rw = 1'($urandom % 2);
            rs = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
            rx = 1'($urandom % 2);
            ridx = ($urandom % 10 < 7) ? int'($urandom % 16) : 510 + int'($urandom % 10);
            ra = 32'(ridx * 4);
            if ($urandom % 2 == 0) ra = ra + 32'($urandom % 4);
            else if (rs == 2'd0) ra = ra + 32'($urandom % 4);
            else if (rs == 2'd1) ra = ra + 32'(2 * ($urandom % 2));
            run_op(rw, rs, rx, ra, $urandom, "rand");
        end

        // Reset during WRITE of a word store aborts it.
        @(negedge clk);
        bus.req = 1'b1; bus.we_in = 1'b1; bus.size = 2'd2; bus.sign_ext = 1'b0;
        bus.addr = 32'h20; bus.wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 bus.req = 1'b0;
        @(negedge clk);
        check("abort mem_we before reset", {31'h0, bus.mem_we}, 32'h1);
        #1 reset = 1'b1;
        #1;
        check("abort mem_we dropped", {31'h0, bus.mem_we}, 32'h0);
        check("abort busy", {31'h0, bus.busy}, 32'h0);
        check("abort done", {31'h0, bus.done}, 32'h0);
        check("abort rdata cleared", bus.rdata, 32'h0);
        exp_rdata = 32'h0;
        @(posedge clk);
        #1 reset = 1'b0;
        we_before = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.done) we_before++;
        end
        check("abort no done", 32'(we_before), 32'h0);
        check("abort word8", mem[8], ref_mem[8]);
        $display("op reset_abort sw 0x20: word8=%h mem_we=%0d", mem[8], bus.mem_we);

        run_op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "lw_after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
